elastic_config_loader: RTL and testbench

- Sequences configuration and execution of an array of elastic PEs.
- Accepts a valid/ready stream of per-context config words and writes them into each PE's context memory through the PE config-load interface (one-hot write strobe per PE).
- After the last word: drives the common mapping_context_max_id and a one-cycle start_exec, then times the execution phase and reports completion.

---
 rtl/elastic_config_loader.sv | 190 +++++++++++++++++++
 tb/tb_elastic_config_loader.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/elastic_config_loader.sv
// rtl/elastic_config_loader.sv - streams per-context config words into an elastic PE array, then starts and times execution
module elastic_config_loader #(
    parameter int PE_NUM                  = 16,
    parameter int PE_INDEX_BIT_LENGTH     = 4,
    parameter int CONTEXT_SIZE            = 16,
    parameter int CONTEXT_SIZE_BIT_LENGTH = 4,
    parameter int INPUT_NUM_BIT_LENGTH    = 3,
    parameter int NEIGHBOR_PE_NUM         = 4,
    parameter int OPERATION_BIT_LENGTH    = 4,
    parameter int DATA_WIDTH              = 32
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               load_start,
    input  logic [CONTEXT_SIZE_BIT_LENGTH:0]   load_context_num,
    input  logic [DATA_WIDTH-1:0]              exec_cycle_limit,
    input  logic                               abort,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_PE_index_1,
    input  logic [INPUT_NUM_BIT_LENGTH-1:0]    cfg_input_PE_index_2,
    input  logic [NEIGHBOR_PE_NUM-1:0]         cfg_output_PE_index,
    input  logic [OPERATION_BIT_LENGTH-1:0]    cfg_op,
    input  logic [DATA_WIDTH-1:0]              cfg_const_data,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_1,
    output logic [INPUT_NUM_BIT_LENGTH-1:0]    config_input_PE_index_2,
    output logic [NEIGHBOR_PE_NUM-1:0]         config_output_PE_index,
    output logic [OPERATION_BIT_LENGTH-1:0]    config_op,
    output logic [DATA_WIDTH-1:0]              config_const_data,
    output logic [PE_NUM-1:0]                  write_config_data,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] config_index,
    output logic                               start_exec,
    output logic [CONTEXT_SIZE_BIT_LENGTH-1:0] mapping_context_max_id,
    output logic                               busy,
    output logic                               done,
    output logic                               error
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_START, S_EXEC} state_t;

    localparam logic [CONTEXT_SIZE_BIT_LENGTH:0]   C_ONE_N    = 1;
    localparam logic [CONTEXT_SIZE_BIT_LENGTH-1:0] C_ONE_CTX  = 1;
    localparam logic [PE_INDEX_BIT_LENGTH-1:0]     C_ONE_PE   = 1;
    localparam logic [DATA_WIDTH-1:0]              C_ONE_DW   = 1;
    localparam logic [CONTEXT_SIZE_BIT_LENGTH:0]   C_CTX_SIZE = CONTEXT_SIZE[CONTEXT_SIZE_BIT_LENGTH:0];
    localparam logic [PE_INDEX_BIT_LENGTH-1:0]     C_PE_LAST  = PE_INDEX_BIT_LENGTH'(PE_NUM - 1);
    localparam logic [PE_NUM-1:0]                  C_PE0_HOT  = {{(PE_NUM-1){1'b0}}, 1'b1};

    state_t                             r_state;
    logic [CONTEXT_SIZE_BIT_LENGTH:0]   r_ctx_num;
    logic [DATA_WIDTH-1:0]              r_limit;
    logic [DATA_WIDTH-1:0]              r_exec_cnt;
    logic [PE_INDEX_BIT_LENGTH-1:0]     r_pe_ptr;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_ctx_ptr;

    logic                               r_cfg_ready;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    r_in1;
    logic [INPUT_NUM_BIT_LENGTH-1:0]    r_in2;
    logic [NEIGHBOR_PE_NUM-1:0]         r_out_idx;
    logic [OPERATION_BIT_LENGTH-1:0]    r_op;
    logic [DATA_WIDTH-1:0]              r_const;
    logic [PE_NUM-1:0]                  r_write;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_cfg_index;
    logic                               r_start_exec;
    logic [CONTEXT_SIZE_BIT_LENGTH-1:0] r_max_id;
    logic                               r_busy;
    logic                               r_done;
    logic                               r_error;

    logic w_hs;
    logic w_num_ok;
    logic w_ctx_last;
    logic w_pe_last;
    logic w_exec_last;

    // A word is taken only while the registered ready is high, so the last word closes the stream cleanly.
    assign w_hs        = cfg_valid & r_cfg_ready;
    assign w_num_ok    = (load_context_num != '0) && (load_context_num <= C_CTX_SIZE);
    assign w_ctx_last  = ({1'b0, r_ctx_ptr} == (r_ctx_num - C_ONE_N));
    assign w_pe_last   = (r_pe_ptr == C_PE_LAST);
    // Compare against limit-1 so the largest representable limit never needs a wider counter.
    assign w_exec_last = (r_limit != '0) && (r_exec_cnt == (r_limit - C_ONE_DW));

    // Single registered FSM: pointers, counters and every output update together; abort overrides all transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ctx_num    <= '0;
            r_limit      <= '0;
            r_exec_cnt   <= '0;
            r_pe_ptr     <= '0;
            r_ctx_ptr    <= '0;
            r_cfg_ready  <= 1'b0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_out_idx    <= '0;
            r_op         <= '0;
            r_const      <= '0;
            r_write      <= '0;
            r_cfg_index  <= '0;
            r_start_exec <= 1'b0;
            r_max_id     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_write      <= '0;
            r_start_exec <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            if (abort) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_cfg_ready <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (load_start) begin
                            if (w_num_ok) begin
                                r_ctx_num   <= load_context_num;
                                r_limit     <= exec_cycle_limit;
                                r_max_id    <= load_context_num[CONTEXT_SIZE_BIT_LENGTH-1:0] - C_ONE_CTX;
                                r_pe_ptr    <= '0;
                                r_ctx_ptr   <= '0;
                                r_state     <= S_LOAD;
                                r_busy      <= 1'b1;
                                r_cfg_ready <= 1'b1;
                            end else begin
                                r_error <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (w_hs) begin
                            r_in1       <= cfg_input_PE_index_1;
                            r_in2       <= cfg_input_PE_index_2;
                            r_out_idx   <= cfg_output_PE_index;
                            r_op        <= cfg_op;
                            r_const     <= cfg_const_data;
                            r_cfg_index <= r_ctx_ptr;
                            r_write     <= C_PE0_HOT << r_pe_ptr;
                            if (w_ctx_last) begin
                                r_ctx_ptr <= '0;
                                r_pe_ptr  <= r_pe_ptr + C_ONE_PE;
                                if (w_pe_last) begin
                                    r_state     <= S_START;
                                    r_cfg_ready <= 1'b0;
                                end
                            end else begin
                                r_ctx_ptr <= r_ctx_ptr + C_ONE_CTX;
                            end
                        end
                    end
                    S_START: begin
                        r_start_exec <= 1'b1;
                        r_exec_cnt   <= '0;
                        r_state      <= S_EXEC;
                    end
                    S_EXEC: begin
                        r_exec_cnt <= r_exec_cnt + C_ONE_DW;
                        if (w_exec_last) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign cfg_ready               = r_cfg_ready;
    assign config_input_PE_index_1 = r_in1;
    assign config_input_PE_index_2 = r_in2;
    assign config_output_PE_index  = r_out_idx;
    assign config_op               = r_op;
    assign config_const_data       = r_const;
    assign write_config_data       = r_write;
    assign config_index            = r_cfg_index;
    assign start_exec              = r_start_exec;
    assign mapping_context_max_id  = r_max_id;
    assign busy                    = r_busy;
    assign done                    = r_done;
    assign error                   = r_error;

endmodule

// File: tb/tb_elastic_config_loader.sv
// tb/tb_elastic_config_loader.sv - randomized directed bench for elastic_config_loader against a word-list model
module tb_elastic_config_loader;

    localparam int PE_NUM = 4;
    localparam int PEB    = 2;
    localparam int CS     = 4;
    localparam int CSB    = 2;
    localparam int INB    = 3;
    localparam int NB     = 4;
    localparam int OPB    = 4;
    localparam int DW     = 32;

    logic clk = 1'b0;
    logic reset;
    logic load_start;
    logic [CSB:0] load_context_num;
    logic [DW-1:0] exec_cycle_limit;
    logic abort;
    logic cfg_valid;
    logic cfg_ready;
    logic [INB-1:0] cfg_input_PE_index_1, cfg_input_PE_index_2;
    logic [NB-1:0] cfg_output_PE_index;
    logic [OPB-1:0] cfg_op;
    logic [DW-1:0] cfg_const_data;
    logic [INB-1:0] config_input_PE_index_1, config_input_PE_index_2;
    logic [NB-1:0] config_output_PE_index;
    logic [OPB-1:0] config_op;
    logic [DW-1:0] config_const_data;
    logic [PE_NUM-1:0] write_config_data;
    logic [CSB-1:0] config_index;
    logic start_exec;
    logic [CSB-1:0] mapping_context_max_id;
    logic busy, done, error;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_max = 0;

    elastic_config_loader #(
        .PE_NUM(PE_NUM), .PE_INDEX_BIT_LENGTH(PEB), .CONTEXT_SIZE(CS),
        .CONTEXT_SIZE_BIT_LENGTH(CSB), .INPUT_NUM_BIT_LENGTH(INB),
        .NEIGHBOR_PE_NUM(NB), .OPERATION_BIT_LENGTH(OPB), .DATA_WIDTH(DW)
    ) dut (
        .clk(clk), .reset(reset), .load_start(load_start),
        .load_context_num(load_context_num), .exec_cycle_limit(exec_cycle_limit),
        .abort(abort), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_input_PE_index_1(cfg_input_PE_index_1), .cfg_input_PE_index_2(cfg_input_PE_index_2),
        .cfg_output_PE_index(cfg_output_PE_index), .cfg_op(cfg_op), .cfg_const_data(cfg_const_data),
        .config_input_PE_index_1(config_input_PE_index_1), .config_input_PE_index_2(config_input_PE_index_2),
        .config_output_PE_index(config_output_PE_index), .config_op(config_op),
        .config_const_data(config_const_data), .write_config_data(write_config_data),
        .config_index(config_index), .start_exec(start_exec),
        .mapping_context_max_id(mapping_context_max_id), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({cfg_ready, config_input_PE_index_1, config_input_PE_index_2, config_output_PE_index,
                    config_op, config_const_data, write_config_data, config_index, start_exec,
                    mapping_context_max_id, busy, done, error});
    endfunction

    // mode 0: valid always, 1: valid toggles 1,0,1,0..., 2: random valid
    task automatic run_load(input int n, input int lim, input int mode, input bit extra_ls);
        int total;
        int acc;
        int cc;
        bit hs;
        bit tgl;
        logic [45:0] w[$];
        total = PE_NUM * n;
        acc = 0;
        cc = 0;
        tgl = 1'b1;
        for (int k = 0; k < total; k++)
            w.push_back({3'($urandom), 3'($urandom), 4'($urandom), 4'(k + 1), 32'($urandom)});
        load_start = 1'b1;
        load_context_num = (CSB+1)'(n);
        exec_cycle_limit = DW'(lim);
        cyc();
        load_start = 1'b0;
        exp_max = n - 1;
        chk("load_busy", 64'(busy), 64'(1));
        chk("load_ready", 64'(cfg_ready), 64'(1));
        while (acc < total && cc < 300) begin
            case (mode)
                0: cfg_valid = 1'b1;
                1: begin cfg_valid = tgl; tgl = ~tgl; end
                default: cfg_valid = 1'($urandom_range(0, 1));
            endcase
            load_start = extra_ls && (cc == 2);
            load_context_num = load_start ? (CSB+1)'(1) : (CSB+1)'(n);
            {cfg_input_PE_index_1, cfg_input_PE_index_2, cfg_output_PE_index, cfg_op, cfg_const_data} = w[acc];
            hs = cfg_valid && cfg_ready;
            cyc();
            cc++;
            if (hs) acc++;
            chk("strobe_iff_handshake", 64'(write_config_data != '0), 64'(hs));
            if (hs) begin
                chk("strobe_onehot", 64'(write_config_data), 64'(4'(1) << ((acc - 1) / n)));
                chk("config_index", 64'(config_index), 64'((acc - 1) % n));
                chk("config_fields", 64'({config_input_PE_index_1, config_input_PE_index_2,
                    config_output_PE_index, config_op, config_const_data}), 64'(w[acc - 1]));
            end
        end
        cfg_valid = 1'b0;
        load_start = 1'b0;
        chk("load_complete", 64'(acc), 64'(total));
        chk("ready_drop_last", 64'(cfg_ready), 64'(0));
        chk("no_start_with_strobe", 64'(start_exec), 64'(0));
        cyc();
        chk("start_exec_after_last", 64'(start_exec), 64'(1));
        chk("no_strobe_at_start", 64'(write_config_data), 64'(0));
        chk("max_id", 64'(mapping_context_max_id), 64'(exp_max));
    endtask

    task automatic wait_done(input int lim);
        int c;
        int starts;
        c = 0;
        starts = 0;
        while (c < lim + 20) begin
            cyc();
            c++;
            if (start_exec) starts++;
            if (done) break;
        end
        chk("done_latency", 64'(c), 64'(lim));
        chk("start_once", 64'(starts), 64'(0));
        cyc();
        chk("done_one_cycle", 64'(done), 64'(0));
        chk("busy_after_done", 64'(busy), 64'(0));
    endtask

    initial begin
        int cnt_a;
        int cnt_b;
        reset = 1'b1; load_start = 1'b0; load_context_num = '0; exec_cycle_limit = '0;
        abort = 1'b0; cfg_valid = 1'b0; cfg_input_PE_index_1 = '0; cfg_input_PE_index_2 = '0;
        cfg_output_PE_index = '0; cfg_op = '0; cfg_const_data = '0;
        cyc(); cyc();
        chk("reset_outputs", all_outs(), 64'(0));
        reset = 1'b0;
        cyc();
        chk("idle_outputs", all_outs(), 64'(0));

        // continuous stream, N=2, limit=5
        run_load(2, 5, 0, 1'b0);
        wait_done(5);

        // toggling valid
        run_load(2, 5, 1, 1'b0);
        wait_done(5);

        // random loads; first one also tries a load_start mid-load
        for (int r = 0; r < 3; r++) begin
            int n;
            int lim;
            n = $urandom_range(1, CS);
            lim = $urandom_range(1, 12);
            run_load(n, lim, 2, r == 0);
            wait_done(lim);
        end

        // illegal context counts
        for (int e = 0; e < 2; e++) begin
            load_start = 1'b1;
            load_context_num = (e == 0) ? (CSB+1)'(0) : (CSB+1)'(CS + 1);
            cyc();
            load_start = 1'b0;
            chk("error_pulse", 64'(error), 64'(1));
            chk("error_busy", 64'(busy), 64'(0));
            chk("error_no_strobe", 64'(write_config_data), 64'(0));
            chk("error_max_id", 64'(mapping_context_max_id), 64'(exp_max));
            cyc();
            chk("error_one_cycle", 64'(error), 64'(0));
        end

        // unbounded execution then abort
        run_load(4, 0, 2, 1'b0);
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 1000; k++) begin
            cyc();
            if (done) cnt_a++;
            if (start_exec) cnt_b++;
        end
        chk("unbounded_no_done", 64'(cnt_a), 64'(0));
        chk("unbounded_no_restart", 64'(cnt_b), 64'(0));
        chk("unbounded_busy", 64'(busy), 64'(1));
        load_start = 1'b1; load_context_num = 3'd1;
        cyc();
        load_start = 1'b0;
        chk("exec_ls_ignored_max", 64'(mapping_context_max_id), 64'(exp_max));
        chk("exec_ls_ignored_ready", 64'(cfg_ready), 64'(0));
        chk("exec_ls_ignored_busy", 64'(busy), 64'(1));
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_pulses", 64'({start_exec, done, cfg_ready}), 64'(0));
        cnt_b = 0;
        for (int k = 0; k < 10; k++) begin cyc(); if (start_exec) cnt_b++; end
        chk("abort_no_restart", 64'(cnt_b), 64'(0));

        // abort after the third accepted word
        load_start = 1'b1; load_context_num = 3'd2; exec_cycle_limit = 32'd3;
        cyc();
        load_start = 1'b0;
        exp_max = 1;
        for (int k = 0; k < 3; k++) begin
            cfg_valid = 1'b1;
            cfg_op = 4'(k + 1);
            cyc();
            chk("abort_load_strobe", 64'(write_config_data), 64'(4'(1) << (k / 2)));
            chk("abort_load_index", 64'(config_index), 64'(k % 2));
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abort_load_ready", 64'(cfg_ready), 64'(0));
        chk("abort_load_strobe_off", 64'(write_config_data), 64'(0));
        chk("abort_load_busy", 64'(busy), 64'(0));
        chk("abort_load_max_id", 64'(mapping_context_max_id), 64'(exp_max));
        cnt_a = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            if (write_config_data != '0 || cfg_ready) cnt_a++;
        end
        chk("abort_load_quiet", 64'(cnt_a), 64'(0));
        cfg_valid = 1'b0;
        run_load(1, 2, 0, 1'b0);
        wait_done(2);

        // asynchronous reset during execution
        run_load(2, 0, 0, 1'b0);
        cyc(); cyc(); cyc();
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", all_outs(), 64'(0));
        cyc();
        reset = 1'b0;
        cyc();
        chk("post_reset_idle", all_outs(), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
